// File: rtl/spi_multitrack_rx_if.sv
// Pin and result bundle for the multi-track SPI receiver.
// The master side drives the SPI pins; the slave side returns the committed track data.
interface spi_multitrack_rx_if #(
  parameter int NUM_TRACKS  = 2,
  parameter int PACKET_SIZE = 24,
  parameter int ERR_W       = 8
);
  logic                              cs;
  logic                              sck;
  logic                              sdi;
  logic [NUM_TRACKS*PACKET_SIZE-1:0] track_data;
  logic [NUM_TRACKS-1:0]             update_mask;
  logic                              data_valid;
  logic                              frame_err;
  logic [ERR_W-1:0]                  err_count;
  logic                              busy;

  modport master (
    output cs, sck, sdi,
    input  track_data, update_mask, data_valid, frame_err, err_count, busy
  );

  modport slave (
    input  cs, sck, sdi,
    output track_data, update_mask, data_valid, frame_err, err_count, busy
  );
endinterface

// File: rtl/spi_multitrack_rx.sv
// Oversampling SPI slave that shifts in MSB-first packets and commits 1..NUM_TRACKS of them
// atomically into the per-track registers at end of frame.
//
// state  | meaning
// IDLE   | waiting for a cs rising edge
// SHIFT  | frame open, sampling sdi on each sck rising edge
// COMMIT | one cycle: check the bit count, then load tracks or flag a frame error
module spi_multitrack_rx #(
  parameter int NUM_TRACKS  = 2,
  parameter int PACKET_SIZE = 24,
  parameter int ERR_W       = 8
) (
  input logic               clk,
  input logic               reset,
  spi_multitrack_rx_if.slave bus
);

  localparam int MAX = NUM_TRACKS * PACKET_SIZE;
  localparam int CW  = $clog2(MAX + 2);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  state_t                  state_q, state_d;
  logic                    cs_m, cs_s, cs_d;
  logic                    sck_m, sck_s, sck_d;
  logic                    sdi_m, sdi_s;
  logic [MAX-1:0]          shift_q, shift_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [MAX-1:0]          track_q, track_d;
  logic [NUM_TRACKS-1:0]   mask_q, mask_d;
  logic                    dv_q, dv_d;
  logic                    fe_q, fe_d;
  logic [ERR_W-1:0]        ec_q, ec_d;
  logic                    cs_rise, cs_fall, sck_rise;
  logic                    frame_ok;

  assign cs_rise  = cs_s & ~cs_d;
  assign cs_fall  = ~cs_s & cs_d;
  assign sck_rise = sck_s & ~sck_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cs_m    <= 1'b0;
      cs_s    <= 1'b0;
      cs_d    <= 1'b0;
      sck_m   <= 1'b0;
      sck_s   <= 1'b0;
      sck_d   <= 1'b0;
      sdi_m   <= 1'b0;
      sdi_s   <= 1'b0;
      shift_q <= '0;
      cnt_q   <= '0;
      track_q <= '0;
      mask_q  <= '0;
      dv_q    <= 1'b0;
      fe_q    <= 1'b0;
      ec_q    <= '0;
    end else begin
      state_q <= state_d;
      cs_m    <= bus.cs;
      cs_s    <= cs_m;
      cs_d    <= cs_s;
      sck_m   <= bus.sck;
      sck_s   <= sck_m;
      sck_d   <= sck_s;
      sdi_m   <= bus.sdi;
      sdi_s   <= sdi_m;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      track_q <= track_d;
      mask_q  <= mask_d;
      dv_q    <= dv_d;
      fe_q    <= fe_d;
      ec_q    <= ec_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    track_d  = track_q;
    mask_d   = '0;
    dv_d     = 1'b0;
    fe_d     = 1'b0;
    ec_d     = ec_q;
    frame_ok = 1'b0;
    case (state_q)
      IDLE: begin
        if (cs_rise) begin
          state_d = SHIFT;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        // cs_s is already low on a coincident fall, so that last sck edge is dropped
        if (cs_fall) begin
          state_d = COMMIT;
        end else if (sck_rise && cs_s) begin
          shift_d = {shift_q[MAX-2:0], sdi_s};
          if (cnt_q != CW'(MAX + 1)) cnt_d = cnt_q + 1'b1;
        end
      end
      COMMIT: begin
        state_d = IDLE;
        // first packet sent sits highest in the shift register and lands in track 0
        for (int k = 1; k <= NUM_TRACKS; k++) begin
          if (cnt_q == CW'(k * PACKET_SIZE)) begin
            frame_ok = 1'b1;
            for (int j = 0; j < k; j++) begin
              track_d[j*PACKET_SIZE +: PACKET_SIZE] = shift_q[(k-j-1)*PACKET_SIZE +: PACKET_SIZE];
              mask_d[j] = 1'b1;
            end
          end
        end
        if (frame_ok) begin
          dv_d = 1'b1;
        end else begin
          fe_d = 1'b1;
          if (ec_q != '1) ec_d = ec_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.track_data  = track_q;
  assign bus.update_mask = mask_q;
  assign bus.data_valid  = dv_q;
  assign bus.frame_err   = fe_q;
  assign bus.err_count   = ec_q;
  assign bus.busy        = cs_s;

endmodule

// File: tb/tb_spi_multitrack_rx.sv
// Bench for spi_multitrack_rx: three instances share the SPI pins (2x24 main, 2x24 with a
// 2-bit error counter, 1x24); commits on the main instance are checked against a queue.
module tb_spi_multitrack_rx;

  logic clk;
  logic reset;
  logic cs, sck, sdi;

  spi_multitrack_rx_if #(.NUM_TRACKS(2), .PACKET_SIZE(24), .ERR_W(8)) bus_main ();
  spi_multitrack_rx_if #(.NUM_TRACKS(2), .PACKET_SIZE(24), .ERR_W(2)) bus_sat ();
  spi_multitrack_rx_if #(.NUM_TRACKS(1), .PACKET_SIZE(24), .ERR_W(8)) bus_one ();

  assign bus_main.cs  = cs;
  assign bus_main.sck = sck;
  assign bus_main.sdi = sdi;
  assign bus_sat.cs   = cs;
  assign bus_sat.sck  = sck;
  assign bus_sat.sdi  = sdi;
  assign bus_one.cs   = cs;
  assign bus_one.sck  = sck;
  assign bus_one.sdi  = sdi;

  spi_multitrack_rx #(.NUM_TRACKS(2), .PACKET_SIZE(24), .ERR_W(8)) dut_main (
    .clk(clk), .reset(reset), .bus(bus_main));
  spi_multitrack_rx #(.NUM_TRACKS(2), .PACKET_SIZE(24), .ERR_W(2)) dut_sat (
    .clk(clk), .reset(reset), .bus(bus_sat));
  spi_multitrack_rx #(.NUM_TRACKS(1), .PACKET_SIZE(24), .ERR_W(8)) dut_one (
    .clk(clk), .reset(reset), .bus(bus_one));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          is_err;
    logic [47:0] td;
    logic [1:0]  mask;
    logic [7:0]  ec;
  } exp_t;

  typedef struct {
    logic [63:0] data;
    int          nbits;
    exp_t        exp;
  } vec_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard: every commit or error pulse on the main instance consumes one expectation
  always @(negedge clk) begin
    if (reset === 1'b1 && (bus_main.data_valid === 1'b1 || bus_main.frame_err === 1'b1)) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected: got dv=%0b fe=%0b expected no pulse",
                 bus_main.data_valid, bus_main.frame_err);
      end else begin
        mon_e = exp_q.pop_front();
        check("sb_frame_err", 64'(bus_main.frame_err), 64'(mon_e.is_err));
        check("sb_data_valid", 64'(bus_main.data_valid), 64'(!mon_e.is_err));
        check("sb_track_data", 64'(bus_main.track_data), 64'(mon_e.td));
        check("sb_update_mask", 64'(bus_main.update_mask), 64'(mon_e.mask));
        check("sb_err_count", 64'(bus_main.err_count), 64'(mon_e.ec));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [63:0] data, input int nbits);
    for (int i = nbits - 1; i >= 0; i--) begin
      sdi = data[i];
      tick(2);
      sck = 1'b1;
      tick(4);
      sck = 1'b0;
      tick(2);
    end
  endtask

  // cycles from the cs pin falling until a result pulse is visible
  task automatic wait_result(output int lat);
    lat = 0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk);
      #1;
      if (i == 4) sck = 1'b0;
      if (lat == 0 && (bus_main.data_valid === 1'b1 || bus_main.frame_err === 1'b1)) lat = i;
    end
  endtask

  task automatic run_frame(input logic [63:0] data, input int nbits, output int lat);
    cs = 1'b1;
    tick(4);
    send_bits(data, nbits);
    tick(2);
    cs = 1'b0;
    wait_result(lat);
  endtask

  vec_t vecs[5];
  exp_t e;
  int   lat;

  initial begin
    vecs[0] = '{64'h0114FF0217FF, 48, '{1'b0, 48'h0217FF_0114FF, 2'b11, 8'd0}};
    vecs[1] = '{64'h0A0B0C,       24, '{1'b0, 48'h0217FF_0A0B0C, 2'b01, 8'd0}};
    vecs[2] = '{64'h1ABCDEF,      25, '{1'b1, 48'h0217FF_0A0B0C, 2'b00, 8'd1}};
    vecs[3] = '{64'h123456789ABCD, 49, '{1'b1, 48'h0217FF_0A0B0C, 2'b00, 8'd2}};
    vecs[4] = '{64'h0,            0,  '{1'b1, 48'h0217FF_0A0B0C, 2'b00, 8'd3}};

    cs = 1'b0; sck = 1'b0; sdi = 1'b0; reset = 1'b0;
    tick(3);
    check("rst_track_data", 64'(bus_main.track_data), 64'd0);
    check("rst_update_mask", 64'(bus_main.update_mask), 64'd0);
    check("rst_data_valid", 64'(bus_main.data_valid), 64'd0);
    check("rst_frame_err", 64'(bus_main.frame_err), 64'd0);
    check("rst_err_count", 64'(bus_main.err_count), 64'd0);
    check("rst_busy", 64'(bus_main.busy), 64'd0);
    check("rst_sat_err_count", 64'(bus_sat.err_count), 64'd0);
    reset = 1'b1;
    tick(4);

    // full frame, partial frame, then the three bad lengths
    for (int v = 0; v < 5; v++) begin
      exp_q.push_back(vecs[v].exp);
      run_frame(vecs[v].data, vecs[v].nbits, lat);
      check($sformatf("latency_vec%0d", v), 64'(lat), 64'd4);
    end
    tick(2);

    // reset while a frame is open: partial frame silently discarded
    cs = 1'b1;
    tick(4);
    send_bits(64'h2D5, 10);
    check("busy_mid_frame", 64'(bus_main.busy), 64'd1);
    cs = 1'b0;
    reset = 1'b0;
    tick(1);
    reset = 1'b1;
    tick(8);
    check("midrst_track_data", 64'(bus_main.track_data), 64'd0);
    check("midrst_err_count", 64'(bus_main.err_count), 64'd0);
    check("midrst_busy", 64'(bus_main.busy), 64'd0);
    check("midrst_sat_err_count", 64'(bus_sat.err_count), 64'd0);

    e = '{1'b0, 48'h789ABC_123456, 2'b11, 8'd0};
    exp_q.push_back(e);
    run_frame(64'h123456789ABC, 48, lat);
    check("latency_after_reset", 64'(lat), 64'd4);
    check("sat_after_reset_frame", 64'(bus_sat.err_count), 64'd0);
    tick(2);

    // five bad frames: the 2-bit counter pins at 3
    for (int i = 0; i < 5; i++) begin
      e = '{1'b1, 48'h789ABC_123456, 2'b00, 8'(i + 1)};
      exp_q.push_back(e);
      run_frame(64'h16, (i % 2 == 0) ? 0 : 5, lat);
      check($sformatf("sat_err_count_%0d", i), 64'(bus_sat.err_count), 64'((i < 2) ? i + 1 : 3));
      check($sformatf("sat_err_main_%0d", i), 64'(bus_main.err_count), 64'(i + 1));
    end
    tick(2);

    // 24 clean bits, then a 25th sck rise on the same clock as cs falling
    e = '{1'b0, 48'h789ABC_A5C3F0, 2'b01, 8'd5};
    exp_q.push_back(e);
    cs = 1'b1;
    tick(4);
    send_bits(64'hA5C3F0, 24);
    sdi = 1'b1;
    tick(2);
    sck = 1'b1;
    cs  = 1'b0;
    wait_result(lat);
    check("coincident_latency", 64'(lat), 64'd4);
    check("coincident_one_track", 64'(bus_one.track_data), 64'hA5C3F0);
    check("coincident_one_err_count", 64'(bus_one.err_count), 64'd6);
    check("coincident_main_track", 64'(bus_main.track_data), 64'h789ABC_A5C3F0);
    tick(4);

    check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_multitrack_rx.md
Name: spi_multitrack_rx

Overview:
- Parametrised SPI slave receiver for the multi-track synth.
- Oversamples the external SPI pins (cs, sck, sdi) in the clk domain and shifts in MSB-first packets of PACKET_SIZE bits each.
- At end of frame, commits 1..NUM_TRACKS packets atomically into per-track holding registers that feed the tone generators.
- Adds partial-frame updates, an update mask, frame-error detection and an error counter.

Parameters:
- NUM_TRACKS, 2, number of tracks / tone generators; 1..8.
- PACKET_SIZE, 24, bits per track packet; 8..32.
- ERR_W, 8, width of saturating frame-error counter.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-low reset.
- cs  input  1  async frame enable; active-high, frame spans cs high.
- sck  input  1  async SPI clock; data sampled on rising edge.
- sdi  input  1  async serial data, MSB first.
- track_data  output  NUM_TRACKS*PACKET_SIZE  packed track registers; track i at [(i+1)*PACKET_SIZE-1 : i*PACKET_SIZE].
- update_mask  output  NUM_TRACKS  one-cycle pulse; bit i set if track i updated this cycle.
- data_valid  output  1  one-cycle pulse on successful commit.
- frame_err  output  1  one-cycle pulse on rejected frame.
- err_count  output  ERR_W  saturating count of rejected frames.
- busy  output  1  synchronised cs; high while a frame is in progress.

Behaviour:
- Reset values (clk edge with reset=0): track_data=0, update_mask=0, data_valid=0, frame_err=0, err_count=0, busy=0, bit counter=0, shift reg=0, sync flops=0.
- Synchronisation: cs, sck, sdi each pass through two flops (cs_s, sck_s, sdi_s), plus one delay flop each for edge detection (cs_d, sck_d).
- Pin timing requirement: sck high and low each >=3 clk periods; sdi stable from 1 clk before sck rise until 2 clk after.
- States: IDLE, SHIFT, COMMIT.
- IDLE -> SHIFT on cs_s rising (cs_s=1, cs_d=0): bit counter cleared, shift reg kept.
- SHIFT, on sck_s rising while cs_s=1: shift reg <= {shift[MAX-2:0], sdi_s}, where MAX=NUM_TRACKS*PACKET_SIZE. Counter increments, saturating at MAX+1 (overflow marker).
- sck edges while cs_s=0 are ignored.
- SHIFT -> COMMIT on cs_s falling (cs_s=0, cs_d=1).
- COMMIT (single cycle, then IDLE): let n = bit count and k = n/PACKET_SIZE.
  - Valid frame: n = k*PACKET_SIZE with 1 <= k <= NUM_TRACKS.
  - Packet j (j=0 first transmitted) = shift[(k-j)*PACKET_SIZE-1 : (k-j-1)*PACKET_SIZE], written to track j.
  - Tracks j >= k hold their value.
  - update_mask = (1<<k)-1, data_valid=1, both for exactly this one cycle.
  - Invalid frame (n=0, n not a multiple of PACKET_SIZE, or n > MAX): no track changes, frame_err=1 for one cycle, err_count += 1 saturating at all-ones.
- Latency: commit outputs are registered. They appear 4 clk edges after the cs pin falls (2 sync + edge detect + COMMIT register), before any sck effect of the next frame.
- Simultaneous events:
  - sck_s rising in the same cycle as cs_s falling: the bit is NOT shifted.
  - cs_s rising in the COMMIT cycle: COMMIT completes, then SHIFT is entered via the next detected rise. Senders must keep cs low >=4 clk between frames.
- Reset mid-frame: all state cleared and track_data zeroed; the partial frame is discarded with no frame_err. Because the sync flops are cleared, a cs still high after reset release is seen as a new rising edge and starts a fresh frame.
- busy = cs_s.
- No combinational path from inputs to outputs.

Test Plan:
1. Full frame, NUM_TRACKS=2, PACKET_SIZE=24: cs high, shift 48'h0114FF0217FF, cs low -> track_data[23:0]=24'h0114FF, [47:24]=24'h0217FF; update_mask=2'b11 and data_valid high for exactly 1 cycle, 4 clks after cs falls.
2. Partial frame after test 1: shift 24'h0A0B0C -> track 0 = 24'h0A0B0C, track 1 holds 24'h0217FF, update_mask=2'b01.
3. Bad length: shift 25 bits -> frame_err 1-cycle pulse, err_count=1, track_data unchanged. Then shift 49 bits -> err_count=2. Then cs toggle with 0 bits -> err_count=3.
4. Saturation, ERR_W=2: 5 bad frames -> err_count stays 2'b11.
5. Reset mid-frame: reset=0 for 1 clk after 10 bits -> all outputs 0, no frame_err. Then a full 48-bit frame commits correctly.
6. sck edge coincident with cs fall in 24-bit/NUM_TRACKS=1 config: 24 clean bits plus a 25th edge aligned to cs fall -> frame valid, track 0 equals the first 24 bits.
